ddr3_axi_arbiter: RTL and testbench

Shares the single AXI-like user port of the DDR3 wrapper between CLIENTS write requesters and CLIENTS read requesters, e.g. the camera frame writer and the HDMI frame reader. The write channel and the read channel are arbitrated independently, each round-robin. A grant is held for one whole burst. The block sits between the frame-buffer clients and the DDR3 wrapper and runs on the wrapper's phy_clk.

---
 rtl/ddr3_arb_pkg.sv | 27 ++
 rtl/ddr3_axi_arbiter_if.sv | 44 ++++
 rtl/ddr3_rr_pick.sv | 34 +++
 rtl/ddr3_axi_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ddr3_axi_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 user-port arbiter.
package ddr3_arb_pkg;

   localparam int ADDR_W = 28;
   localparam int LEN_W  = 4;

   // Per-channel arbitration state.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   // Observability bundle: FSM states and sticky beat-count errors.
   typedef struct packed {
      arb_state_e wr_state;
      arb_state_e rd_state;
      logic       err_wr;
      logic       err_rd;
   } arb_dbg_t;

   // Width of one user-port data beat for a given DQ width (16 -> 128, 32 -> 256).
   function automatic int data_len(input int dq_width);
      return (dq_width == 32) ? 256 : 128;
   endfunction

endpackage

// File: rtl/ddr3_axi_arbiter_if.sv
// AXI-like user port of the DDR3 wrapper, seen from the arbiter (master) side.
// Handshake: a transfer happens on a clock where valid and ready are both high;
// once raised, valid and its payload stay stable until that clock. The data
// channels carry no valid from the master: the wrapper pulls write beats with
// axi_wready and pushes read beats with axi_rvalid.
interface ddr3_axi_arbiter_if
   import ddr3_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 16
);
   localparam int DATA_LEN = data_len(DATA_WIDTH);

   logic [ADDR_W-1:0]     axi_awaddr;
   logic [LEN_W-1:0]      axi_awlen;
   logic                  axi_awvalid;
   logic                  axi_awready;
   logic [DATA_LEN-1:0]   axi_wdata;
   logic [DATA_WIDTH-1:0] axi_wstrb;
   logic                  axi_wready;
   logic                  axi_wusero_last;
   logic [ADDR_W-1:0]     axi_araddr;
   logic [LEN_W-1:0]      axi_arlen;
   logic                  axi_arvalid;
   logic                  axi_arready;
   logic [DATA_LEN-1:0]   axi_rdata;
   logic                  axi_rvalid;
   logic                  axi_rlast;
   logic [3:0]            axi_rid;

   modport master (
      output axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb,
      output axi_araddr, axi_arlen, axi_arvalid,
      input  axi_awready, axi_wready, axi_wusero_last,
      input  axi_arready, axi_rdata, axi_rvalid, axi_rlast, axi_rid
   );

   modport slave (
      input  axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb,
      input  axi_araddr, axi_arlen, axi_arvalid,
      output axi_awready, axi_wready, axi_wusero_last,
      output axi_arready, axi_rdata, axi_rvalid, axi_rlast, axi_rid
   );

endinterface

// File: rtl/ddr3_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module ddr3_rr_pick #(
   parameter int CLIENTS = 2,
   parameter int IDX_W   = 1
) (
   input  logic [CLIENTS-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [CLIENTS-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);

   // Scan CLIENTS positions starting at ptr; the first hit wins.
   always_comb begin
      logic             found;
      int               j;
      logic [IDX_W-1:0] jj;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int i = 0; i < CLIENTS; i++) begin
         j = int'(ptr) + i;
         if (j >= CLIENTS) j = j - CLIENTS;
         jj = IDX_W'(j);
         if (!found && req[jj]) begin
            found   = 1'b1;
            gnt[jj] = 1'b1;
            idx     = jj;
         end
      end
   end

endmodule

// File: rtl/ddr3_axi_arbiter.sv
// Shares the DDR3 wrapper user port between CLIENTS writers and CLIENTS readers.
// Write and read channels are arbitrated independently, round-robin, one burst per grant.
module ddr3_axi_arbiter
   import ddr3_arb_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int CLIENTS    = 2,
   localparam int DATA_LEN   = data_len(DATA_WIDTH),
   localparam int IDX_W      = $clog2(CLIENTS)
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           inited,
   input  logic [CLIENTS-1:0]             wr_req,
   input  logic [CLIENTS*ADDR_W-1:0]      wr_addr,
   input  logic [CLIENTS*LEN_W-1:0]       wr_len,
   input  logic [CLIENTS*DATA_LEN-1:0]    wr_data,
   input  logic [CLIENTS*DATA_WIDTH-1:0]  wr_strb,
   output logic [CLIENTS-1:0]             wr_grant,
   output logic [CLIENTS-1:0]             wr_ready,
   output logic [CLIENTS-1:0]             wr_done,
   input  logic [CLIENTS-1:0]             rd_req,
   input  logic [CLIENTS*ADDR_W-1:0]      rd_addr,
   input  logic [CLIENTS*LEN_W-1:0]       rd_len,
   output logic [CLIENTS-1:0]             rd_grant,
   output logic [CLIENTS-1:0]             rd_done,
   output logic [DATA_LEN-1:0]            rd_data,
   output logic [CLIENTS-1:0]             rd_valid,
   ddr3_axi_arbiter_if.master             axi
);

   arb_state_e         wr_state, wr_state_nxt, rd_state, rd_state_nxt;
   logic [IDX_W-1:0]   wr_ptr, wr_idx, wr_pick_idx, rd_ptr, rd_idx, rd_pick_idx;
   logic [CLIENTS-1:0] wr_pick_gnt, rd_pick_gnt;
   logic [LEN_W-1:0]   wr_beat, rd_beat;
   logic               err_wr, err_rd;
   logic               wr_start, wr_last, rd_start, rd_last;

   // Probe for FSM states and sticky errors; not consumed by any logic.
   arb_dbg_t           dbg_unused;
   logic               rid_unused;

   assign dbg_unused = '{wr_state: wr_state, rd_state: rd_state, err_wr: err_wr, err_rd: err_rd};
   assign rid_unused = ^axi.axi_rid;

   ddr3_rr_pick #(.CLIENTS(CLIENTS), .IDX_W(IDX_W)) u_wr_pick (
      .req(wr_req), .ptr(wr_ptr), .gnt(wr_pick_gnt), .idx(wr_pick_idx)
   );

   ddr3_rr_pick #(.CLIENTS(CLIENTS), .IDX_W(IDX_W)) u_rd_pick (
      .req(rd_req), .ptr(rd_ptr), .gnt(rd_pick_gnt), .idx(rd_pick_idx)
   );

   assign wr_start = (wr_state == IDLE) && inited && (|wr_req);
   assign wr_last  = (wr_state == DATA) && axi.axi_wready && axi.axi_wusero_last;
   assign rd_start = (rd_state == IDLE) && inited && (|rd_req);
   assign rd_last  = (rd_state == DATA) && axi.axi_rvalid && axi.axi_rlast;

   // ---------------- write channel ----------------

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) wr_state <= IDLE;
      else       wr_state <= wr_state_nxt;
   end

   // Write FSM next state: IDLE -> ADDR on grant, -> DATA on awready, -> IDLE on last beat.
   always_comb begin
      wr_state_nxt = wr_state;
      unique case (wr_state)
         IDLE:    if (wr_start) wr_state_nxt = ADDR;
         ADDR:    if (axi.axi_awready) wr_state_nxt = DATA;
         DATA:    if (wr_last) wr_state_nxt = IDLE;
         default: wr_state_nxt = IDLE;
      endcase
   end

   // Write grant, address latch, pointer rotation and beat bookkeeping.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_grant        <= '0;
         wr_idx          <= '0;
         wr_ptr          <= '0;
         wr_beat         <= '0;
         err_wr          <= 1'b0;
         axi.axi_awaddr  <= '0;
         axi.axi_awlen   <= '0;
         axi.axi_awvalid <= 1'b0;
      end else begin
         if (wr_start) begin
            wr_grant        <= wr_pick_gnt;
            wr_idx          <= wr_pick_idx;
            wr_beat         <= '0;
            axi.axi_awaddr  <= wr_addr[int'(wr_pick_idx)*ADDR_W +: ADDR_W];
            axi.axi_awlen   <= wr_len[int'(wr_pick_idx)*LEN_W +: LEN_W];
            axi.axi_awvalid <= 1'b1;
         end
         if (wr_state == ADDR && axi.axi_awready) axi.axi_awvalid <= 1'b0;
         if (wr_state == DATA && axi.axi_wready) begin
            wr_beat <= wr_beat + 1'b1;
            if (axi.axi_wusero_last) begin
               wr_grant <= '0;
               wr_ptr   <= (wr_idx == IDX_W'(CLIENTS-1)) ? '0 : wr_idx + 1'b1;
               if (wr_beat != axi.axi_awlen) err_wr <= 1'b1;
            end
         end
      end
   end

   // Write data-phase strobes and data/strobe mux from the granted client.
   always_comb begin
      wr_ready      = '0;
      wr_done       = '0;
      axi.axi_wdata = wr_data[int'(wr_idx)*DATA_LEN +: DATA_LEN];
      axi.axi_wstrb = wr_strb[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
      if (wr_state == DATA) begin
         wr_ready = wr_grant & {CLIENTS{axi.axi_wready}};
         if (axi.axi_wusero_last) wr_done = wr_ready;
      end
   end

   // ---------------- read channel ----------------

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) rd_state <= IDLE;
      else       rd_state <= rd_state_nxt;
   end

   // Read FSM next state: IDLE -> ADDR on grant, -> DATA on arready, -> IDLE on rlast beat.
   always_comb begin
      rd_state_nxt = rd_state;
      unique case (rd_state)
         IDLE:    if (rd_start) rd_state_nxt = ADDR;
         ADDR:    if (axi.axi_arready) rd_state_nxt = DATA;
         DATA:    if (rd_last) rd_state_nxt = IDLE;
         default: rd_state_nxt = IDLE;
      endcase
   end

   // Read grant, address latch, pointer rotation and beat bookkeeping.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_grant        <= '0;
         rd_idx          <= '0;
         rd_ptr          <= '0;
         rd_beat         <= '0;
         err_rd          <= 1'b0;
         axi.axi_araddr  <= '0;
         axi.axi_arlen   <= '0;
         axi.axi_arvalid <= 1'b0;
      end else begin
         if (rd_start) begin
            rd_grant        <= rd_pick_gnt;
            rd_idx          <= rd_pick_idx;
            rd_beat         <= '0;
            axi.axi_araddr  <= rd_addr[int'(rd_pick_idx)*ADDR_W +: ADDR_W];
            axi.axi_arlen   <= rd_len[int'(rd_pick_idx)*LEN_W +: LEN_W];
            axi.axi_arvalid <= 1'b1;
         end
         if (rd_state == ADDR && axi.axi_arready) axi.axi_arvalid <= 1'b0;
         if (rd_state == DATA && axi.axi_rvalid) begin
            rd_beat <= rd_beat + 1'b1;
            if (axi.axi_rlast) begin
               rd_grant <= '0;
               rd_ptr   <= (rd_idx == IDX_W'(CLIENTS-1)) ? '0 : rd_idx + 1'b1;
               if (rd_beat != axi.axi_arlen) err_rd <= 1'b1;
            end
         end
      end
   end

   // Read data broadcast and per-client beat/done strobes.
   always_comb begin
      rd_valid = '0;
      rd_done  = '0;
      if (rd_state == DATA) begin
         rd_valid = rd_grant & {CLIENTS{axi.axi_rvalid}};
         if (axi.axi_rlast) rd_done = rd_valid;
      end
   end

   assign rd_data = axi.axi_rdata;

endmodule

// File: tb/tb_ddr3_axi_arbiter.sv
// Self-checking bench for ddr3_axi_arbiter: bench plays the DDR3 wrapper and the clients.
module tb_ddr3_axi_arbiter;
   import ddr3_arb_pkg::*;

   localparam int DW = 16;
   localparam int NC = 2;
   localparam int DL = 128;

   logic            clk = 1'b0;
   logic            rstn, inited;
   logic [NC-1:0]   wr_req, rd_req;
   logic [NC*28-1:0] wr_addr, rd_addr;
   logic [NC*4-1:0] wr_len, rd_len;
   logic [NC*DL-1:0] wr_data;
   logic [NC*DW-1:0] wr_strb;
   logic [NC-1:0]   wr_grant, wr_ready, wr_done, rd_grant, rd_done, rd_valid;
   logic [DL-1:0]   rd_data;

   int errors = 0;
   int checks = 0;
   logic [DL-1:0] exp_wq[$];
   logic [DL-1:0] exp_rq[$];

   ddr3_axi_arbiter_if #(.DATA_WIDTH(DW)) axi ();

   ddr3_axi_arbiter #(.DATA_WIDTH(DW), .CLIENTS(NC)) dut (
      .clk(clk), .rstn(rstn), .inited(inited),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_grant(wr_grant), .wr_ready(wr_ready), .wr_done(wr_done),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_grant(rd_grant), .rd_done(rd_done), .rd_data(rd_data), .rd_valid(rd_valid),
      .axi(axi)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Wrapper side of one write burst, entered with the DUT in ADDR.
   task automatic serve_write(input int c, input logic [27:0] a, input logic [3:0] l,
                              input int aw_delay, input int nbeats);
      int pulses;
      int b;
      logic [DL-1:0] d, got;
      logic [NC-1:0] exp_v, exp_d;
      pulses = 0;
      for (int i = 0; i <= aw_delay; i++) begin
         checks++;
         if (axi.axi_awvalid !== 1'b1 || axi.axi_awaddr !== a || axi.axi_awlen !== l) begin
            errors++;
            $display("FAIL aw_hold c%0d i%0d: valid=%b addr=%h len=%h want 1 %h %h",
                     c, i, axi.axi_awvalid, axi.axi_awaddr, axi.axi_awlen, a, l);
         end
         axi.axi_awready = (i == aw_delay);
         cyc();
      end
      axi.axi_awready = 1'b0;
      checks++;
      if (axi.axi_awvalid !== 1'b0) begin
         errors++;
         $display("FAIL aw_drop c%0d: awvalid=%b want 0", c, axi.axi_awvalid);
      end
      exp_v = NC'(1) << c;
      b = 0;
      while (b < nbeats) begin
         if ($urandom_range(0, 3) == 0) begin
            axi.axi_wready = 1'b0;
            axi.axi_wusero_last = 1'b1;
            #1;
            checks++;
            if (wr_ready !== '0 || wr_done !== '0) begin
               errors++;
               $display("FAIL w_gap c%0d: ready=%b done=%b want 0 0", c, wr_ready, wr_done);
            end
         end else begin
            d = {$urandom, $urandom, $urandom, $urandom};
            wr_data[c*DL +: DL] = d;
            exp_wq.push_back(d);
            axi.axi_wready = 1'b1;
            axi.axi_wusero_last = (b == nbeats - 1);
            #1;
            if (wr_ready[c] === 1'b1 && exp_wq.size() > 0) begin
               pulses++;
               got = exp_wq.pop_front();
               checks++;
               if (axi.axi_wdata !== got) begin
                  errors++;
                  $display("FAIL wdata c%0d b%0d: got %h want %h", c, b, axi.axi_wdata, got);
               end
            end
            exp_d = (b == nbeats - 1) ? exp_v : '0;
            checks++;
            if (wr_ready !== exp_v || wr_done !== exp_d) begin
               errors++;
               $display("FAIL w_beat c%0d b%0d: ready=%b done=%b want %b %b",
                        c, b, wr_ready, wr_done, exp_v, exp_d);
            end
            b++;
         end
         cyc();
      end
      axi.axi_wready = 1'b0;
      axi.axi_wusero_last = 1'b0;
      checks++;
      if (pulses != nbeats) begin
         errors++;
         $display("FAIL wr_ready_count c%0d: got %0d want %0d", c, pulses, nbeats);
      end
      checks++;
      if (wr_grant !== '0 || dut.dbg_unused.wr_state !== IDLE) begin
         errors++;
         $display("FAIL wr_release c%0d: grant=%b state=%0d want 0 IDLE", c, wr_grant,
                  dut.dbg_unused.wr_state);
      end
      checks++;
      if (exp_wq.size() != 0) begin
         errors++;
         $display("FAIL wq_leftover c%0d: got %0d entries want 0", c, exp_wq.size());
      end
      exp_wq.delete();
   endtask

   // Wrapper side of one read burst, entered with the DUT in ADDR; rlast on beat nbeats.
   task automatic serve_read(input int c, input logic [27:0] a, input logic [3:0] l,
                             input int ar_delay, input int nbeats);
      int pulses;
      int b;
      logic [DL-1:0] d, got;
      logic [NC-1:0] exp_v, exp_d;
      pulses = 0;
      for (int i = 0; i <= ar_delay; i++) begin
         checks++;
         if (axi.axi_arvalid !== 1'b1 || axi.axi_araddr !== a || axi.axi_arlen !== l) begin
            errors++;
            $display("FAIL ar_hold c%0d i%0d: valid=%b addr=%h len=%h want 1 %h %h",
                     c, i, axi.axi_arvalid, axi.axi_araddr, axi.axi_arlen, a, l);
         end
         axi.axi_arready = (i == ar_delay);
         cyc();
      end
      axi.axi_arready = 1'b0;
      checks++;
      if (axi.axi_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL ar_drop c%0d: arvalid=%b want 0", c, axi.axi_arvalid);
      end
      exp_v = NC'(1) << c;
      b = 0;
      while (b < nbeats) begin
         if ($urandom_range(0, 3) == 0) begin
            axi.axi_rvalid = 1'b0;
            axi.axi_rlast = 1'b1;
            #1;
            checks++;
            if (rd_valid !== '0 || rd_done !== '0) begin
               errors++;
               $display("FAIL r_gap c%0d: valid=%b done=%b want 0 0", c, rd_valid, rd_done);
            end
         end else begin
            d = {$urandom, $urandom, $urandom, $urandom};
            axi.axi_rdata = d;
            exp_rq.push_back(d);
            axi.axi_rvalid = 1'b1;
            axi.axi_rlast = (b == nbeats - 1);
            #1;
            if (rd_valid[c] === 1'b1 && exp_rq.size() > 0) begin
               pulses++;
               got = exp_rq.pop_front();
               checks++;
               if (rd_data !== got) begin
                  errors++;
                  $display("FAIL rdata c%0d b%0d: got %h want %h", c, b, rd_data, got);
               end
            end
            exp_d = (b == nbeats - 1) ? exp_v : '0;
            checks++;
            if (rd_valid !== exp_v || rd_done !== exp_d) begin
               errors++;
               $display("FAIL r_beat c%0d b%0d: valid=%b done=%b want %b %b",
                        c, b, rd_valid, rd_done, exp_v, exp_d);
            end
            b++;
         end
         cyc();
      end
      axi.axi_rvalid = 1'b0;
      axi.axi_rlast = 1'b0;
      checks++;
      if (pulses != nbeats) begin
         errors++;
         $display("FAIL rd_valid_count c%0d: got %0d want %0d", c, pulses, nbeats);
      end
      checks++;
      if (rd_grant !== '0 || dut.dbg_unused.rd_state !== IDLE) begin
         errors++;
         $display("FAIL rd_release c%0d: grant=%b state=%0d want 0 IDLE", c, rd_grant,
                  dut.dbg_unused.rd_state);
      end
      checks++;
      if (exp_rq.size() != 0) begin
         errors++;
         $display("FAIL rq_leftover c%0d: got %0d entries want 0", c, exp_rq.size());
      end
      exp_rq.delete();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      inited = 1'b1;
      wr_req = 2'b11;
      wr_addr[0 +: 28] = 28'h0001000;
      wr_addr[28 +: 28] = 28'h0002000;
      wr_len = {4'd1, 4'd3};
      repeat (3) cyc();
      checks++;
      if ({wr_grant, wr_ready, wr_done, rd_grant, rd_valid, rd_done,
           axi.axi_awvalid, axi.axi_arvalid} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0", {wr_grant, wr_ready, wr_done, rd_grant,
                  rd_valid, rd_done, axi.axi_awvalid, axi.axi_arvalid});
      end
      checks++;
      if ({axi.axi_awaddr, axi.axi_awlen, axi.axi_araddr, axi.axi_arlen} !== '0) begin
         errors++;
         $display("FAIL reset_addr: aw=%h/%h ar=%h/%h want 0", axi.axi_awaddr, axi.axi_awlen,
                  axi.axi_araddr, axi.axi_arlen);
      end
      checks++;
      if (dut.dbg_unused.wr_state !== IDLE || dut.dbg_unused.rd_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: wr=%0d rd=%0d want IDLE", dut.dbg_unused.wr_state,
                  dut.dbg_unused.rd_state);
      end
      rstn = 1'b1;
      cyc();
      checks++;
      if (wr_grant !== 2'b01) begin
         errors++;
         $display("FAIL first_grant: got %b want 01", wr_grant);
      end
      serve_write(0, 28'h0001000, 4'd3, 0, 4);
      cyc();
      checks++;
      if (wr_grant !== 2'b10) begin
         errors++;
         $display("FAIL second_grant: got %b want 10", wr_grant);
      end
      serve_write(1, 28'h0002000, 4'd1, 0, 2);
      cyc();
      checks++;
      if (wr_grant !== 2'b01) begin
         errors++;
         $display("FAIL rotate_back: got %b want 01", wr_grant);
      end
      wr_req = 2'b00;
      serve_write(0, 28'h0001000, 4'd3, 0, 4);
   endtask

   task automatic test_aw_delay();
      wr_req = 2'b01;
      cyc();
      checks++;
      if (wr_grant !== 2'b01 || axi.axi_awvalid !== 1'b1) begin
         errors++;
         $display("FAIL aw_delay_grant: grant=%b awvalid=%b want 01 1", wr_grant, axi.axi_awvalid);
      end
      wr_req = 2'b00;
      serve_write(0, 28'h0001000, 4'd3, 5, 4);
   endtask

   task automatic test_concurrent();
      wr_addr[0 +: 28] = 28'h0003000;
      wr_len[0 +: 4] = 4'd2;
      rd_addr[28 +: 28] = 28'h0004000;
      rd_len[4 +: 4] = 4'd7;
      wr_req = 2'b01;
      rd_req = 2'b10;
      cyc();
      checks++;
      if (wr_grant !== 2'b01 || rd_grant !== 2'b10) begin
         errors++;
         $display("FAIL concurrent_grant: wr=%b rd=%b want 01 10", wr_grant, rd_grant);
      end
      wr_req = 2'b00;
      rd_req = 2'b00;
      fork
         serve_write(0, 28'h0003000, 4'd2, 1, 3);
         serve_read(1, 28'h0004000, 4'd7, 3, 8);
      join
   endtask

   task automatic test_inited();
      inited = 1'b0;
      wr_req = 2'b01;
      for (int i = 0; i < 20; i++) begin
         cyc();
         checks++;
         if (axi.axi_awvalid !== 1'b0 || wr_grant !== '0) begin
            errors++;
            $display("FAIL inited_block i%0d: awvalid=%b grant=%b want 0 0", i, axi.axi_awvalid,
                     wr_grant);
         end
      end
      inited = 1'b1;
      cyc();
      checks++;
      if (axi.axi_awvalid !== 1'b1 || wr_grant !== 2'b01) begin
         errors++;
         $display("FAIL inited_release: awvalid=%b grant=%b want 1 01", axi.axi_awvalid, wr_grant);
      end
      wr_req = 2'b00;
      inited = 1'b0;
      serve_write(0, 28'h0003000, 4'd2, 0, 3);
      inited = 1'b1;
   endtask

   task automatic test_reset_mid_read();
      rd_addr[0 +: 28] = 28'h0005000;
      rd_len[0 +: 4] = 4'd3;
      rd_req = 2'b01;
      cyc();
      rd_req = 2'b00;
      axi.axi_arready = 1'b1;
      cyc();
      axi.axi_arready = 1'b0;
      axi.axi_rdata = {$urandom, $urandom, $urandom, $urandom};
      axi.axi_rvalid = 1'b1;
      #1;
      checks++;
      if (rd_valid !== 2'b01) begin
         errors++;
         $display("FAIL mid_read_beat: rd_valid=%b want 01", rd_valid);
      end
      cyc();
      rstn = 1'b0;
      cyc();
      checks++;
      if ({rd_grant, rd_valid, rd_done, wr_grant, wr_ready, wr_done,
           axi.axi_arvalid, axi.axi_awvalid} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %b want 0", {rd_grant, rd_valid, rd_done,
                  wr_grant, wr_ready, wr_done, axi.axi_arvalid, axi.axi_awvalid});
      end
      checks++;
      if (dut.dbg_unused.rd_state !== IDLE) begin
         errors++;
         $display("FAIL mid_reset_state: rd=%0d want IDLE", dut.dbg_unused.rd_state);
      end
      axi.axi_rvalid = 1'b0;
      rstn = 1'b1;
      rd_req = 2'b01;
      cyc();
      checks++;
      if (rd_grant !== 2'b01) begin
         errors++;
         $display("FAIL post_reset_grant: got %b want 01", rd_grant);
      end
      rd_req = 2'b00;
      serve_read(0, 28'h0005000, 4'd3, 0, 4);
      checks++;
      if (dut.dbg_unused.err_rd !== 1'b0) begin
         errors++;
         $display("FAIL err_rd_clean: got %b want 0", dut.dbg_unused.err_rd);
      end
   endtask

   task automatic test_early_rlast();
      rd_req = 2'b01;
      cyc();
      rd_req = 2'b00;
      serve_read(0, 28'h0005000, 4'd3, 0, 2);
      checks++;
      if (dut.dbg_unused.err_rd !== 1'b1) begin
         errors++;
         $display("FAIL err_rd_set: got %b want 1", dut.dbg_unused.err_rd);
      end
      rd_req = 2'b10;
      cyc();
      rd_req = 2'b00;
      serve_read(1, 28'h0004000, 4'd7, 1, 8);
      checks++;
      if (dut.dbg_unused.err_rd !== 1'b1 || dut.dbg_unused.err_wr !== 1'b0) begin
         errors++;
         $display("FAIL err_sticky: err_rd=%b err_wr=%b want 1 0", dut.dbg_unused.err_rd,
                  dut.dbg_unused.err_wr);
      end
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      cyc();
      checks++;
      if (dut.dbg_unused.err_rd !== 1'b0) begin
         errors++;
         $display("FAIL err_rd_reset: got %b want 0", dut.dbg_unused.err_rd);
      end
   endtask

   initial begin
      rstn = 1'b0;
      inited = 1'b0;
      wr_req = '0;
      rd_req = '0;
      wr_addr = '0;
      rd_addr = '0;
      wr_len = '0;
      rd_len = '0;
      wr_data = '0;
      wr_strb = {$urandom} & 32'hffff_ffff;
      axi.axi_awready = 1'b0;
      axi.axi_wready = 1'b0;
      axi.axi_wusero_last = 1'b0;
      axi.axi_arready = 1'b0;
      axi.axi_rdata = '0;
      axi.axi_rvalid = 1'b0;
      axi.axi_rlast = 1'b0;
      axi.axi_rid = 4'h3;
      test_reset();
      test_aw_delay();
      test_concurrent();
      test_inited();
      test_reset_mid_read();
      test_early_rlast();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
